// File: rtl/apb_master_arbiter.sv
// Two-client round-robin APB requester: arbitrates, sequences SETUP/ACCESS on the
// shared slave bus, returns the response to the owner, and aborts hung slaves.
module apb_master_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            req,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [5:0]            req_prot,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  timeout,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     addr,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_W-1:0]     pwdata,
  output logic [2:0]            prot,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_W-1:0]     prdata
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state, state_d;
  logic               last_gnt, last_gnt_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [1:0]         gnt_d, done_d, eligible;
  logic               win;
  logic               err_d, timeout_d, pwrite_d, psel_d, penable_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  rdata_d, pwdata_d;
  logic [2:0]         prot_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      timeout  <= 1'b0;
      pwrite   <= 1'b0;
      addr     <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwdata   <= '0;
      prot     <= '0;
    end else begin
      state    <= state_d;
      last_gnt <= last_gnt_d;
      cnt      <= cnt_d;
      gnt      <= gnt_d;
      done     <= done_d;
      rdata    <= rdata_d;
      err      <= err_d;
      timeout  <= timeout_d;
      pwrite   <= pwrite_d;
      addr     <= addr_d;
      psel     <= psel_d;
      penable  <= penable_d;
      pwdata   <= pwdata_d;
      prot     <= prot_d;
    end
  end

  // The client finishing this cycle is excluded so the other one gets the next slot.
  always_comb begin
    eligible = req & ~done;
    win      = eligible[~last_gnt] ? ~last_gnt : last_gnt;
  end

  always_comb begin
    state_d    = state;
    last_gnt_d = last_gnt;
    cnt_d      = cnt;
    gnt_d      = gnt;
    done_d     = '0;
    rdata_d    = rdata;
    err_d      = 1'b0;
    timeout_d  = 1'b0;
    pwrite_d   = pwrite;
    addr_d     = addr;
    psel_d     = psel;
    penable_d  = penable;
    pwdata_d   = pwdata;
    prot_d     = prot;
    unique case (state)
      IDLE: begin
        if (eligible != 2'b00) begin
          state_d    = SETUP;
          last_gnt_d = win;
          gnt_d      = win ? 2'b10 : 2'b01;
          pwrite_d   = req_write[win];
          addr_d     = win ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
          prot_d     = win ? req_prot[3 +: 3] : req_prot[0 +: 3];
          pwdata_d   = !req_write[win] ? '0 :
                       (win ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W]);
          psel_d     = 1'b1;
          penable_d  = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready || cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gnt_d     = '0;
          done_d    = gnt;
          if (pready) begin
            err_d = pslverr;
            if (!pwrite) rdata_d = prdata;
          end else begin
            err_d     = 1'b1;
            timeout_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: the bench plays both clients and the APB
// slave; expected completions are queued at request time and popped on done.
module tb_apb_master_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            resetn;
  logic [1:0]      req, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [5:0]      req_prot;
  logic [1:0]      gnt, done;
  logic [DW-1:0]   rdata, pwdata, prdata;
  logic            err, timeout, pwrite, psel, penable, pready, pslverr;
  logic [AW-1:0]   addr;
  logic [2:0]      prot;

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_prot(req_prot), .gnt(gnt), .done(done), .rdata(rdata),
    .err(err), .timeout(timeout), .pwrite(pwrite), .addr(addr), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prot(prot), .pready(pready),
    .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic        to;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          psel_viol = 0;
  logic [31:0] model_rdata;
  int          idle, edges;

  always @(negedge clk)
    if (resetn === 1'b1 && psel === 1'b1 && gnt !== 2'b01 && gnt !== 2'b10) psel_viol++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] d, input logic e, input logic t);
    sb.push_back('{done: d, err: e, to: t, rdata: model_rdata});
  endtask

  task automatic set_client(input int i, input logic w, input logic [AW-1:0] a,
                            input logic [31:0] wd, input logic [2:0] p);
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = wd;
    req_prot[i*3 +: 3]    = p;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " gnt"}, gnt, 0);
    check({tag, " done"}, done, 0);
    check({tag, " rdata"}, rdata, 0);
    check({tag, " err/to"}, {err, timeout}, 0);
    check({tag, " psel/penable"}, {psel, penable}, 0);
    check({tag, " pwrite/addr/prot"}, {pwrite, addr, prot}, 0);
    check({tag, " pwdata"}, pwdata, 0);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp_gnt, output int n);
    n = 0;
    while (psel !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " psel"}, psel, 1);
    check({tag, " gnt"}, gnt, exp_gnt);
    check({tag, " setup penable"}, penable, 0);
  endtask

  task automatic check_bus(input string tag, input logic w, input logic [AW-1:0] a,
                           input logic [31:0] wd, input logic [2:0] p);
    check({tag, " pwrite"}, pwrite, w);
    check({tag, " addr"}, addr, a);
    check({tag, " pwdata"}, pwdata, w ? wd : 32'h0);
    check({tag, " prot"}, prot, p);
  endtask

  // Entered in the SETUP cycle; returns edges from the grant edge to the done edge.
  task automatic finish(input string tag, input int waits, input logic slv,
                        input logic [31:0] prd, input logic stuck, output int n);
    exp_t e;
    @(posedge clk); #1; n = 1;
    check({tag, " access penable"}, {psel, penable}, 2'b11);
    pslverr = 1'b1;
    prdata  = 32'hBADB_AD00;
    if (stuck) begin
      while (done === 2'b00 && n < 40) begin
        @(posedge clk); #1; n++;
      end
    end else begin
      repeat (waits) begin
        @(posedge clk); #1; n++;
      end
      pready  = 1'b1;
      pslverr = slv;
      prdata  = prd;
      @(posedge clk); #1; n++;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, " done"}, done, e.done);
      check({tag, " err"}, err, e.err);
      check({tag, " timeout"}, timeout, e.to);
      check({tag, " rdata"}, rdata, e.rdata);
    end
    check({tag, " bus released"}, {psel, penable, gnt}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    resetn = 1'b0; req = 2'b11; req_write = '0; req_addr = '0; req_wdata = '0; req_prot = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0; model_rdata = '0;
    set_client(0, 1'b1, 5'd1, 32'hA5A5_0001, 3'b000);
    set_client(1, 1'b0, 5'd1, 32'h0, 3'b010);

    // Reset held with both requesting: everything zero, then client 0 wins the first tie.
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    push(2'b01, 1'b0, 1'b0);
    resetn = 1'b1;
    wait_grant("wr", 2'b01, idle);
    req = 2'b00;
    check_bus("wr", 1'b1, 5'd1, 32'hA5A5_0001, 3'b000);
    finish("wr", 0, 1'b0, 32'h1234_5678, 1'b0, edges);
    check("wr latency", edges, 2);

    // Client 1 read, 3 wait states, slave error.
    model_rdata = 32'hDEAD_BEEF;
    push(2'b10, 1'b1, 1'b0);
    req = 2'b10;
    wait_grant("rd", 2'b10, idle);
    check_bus("rd", 1'b0, 5'd1, 32'h0, 3'b010);
    finish("rd", 3, 1'b1, 32'hDEAD_BEEF, 1'b0, edges);
    check("rd latency", edges, 5);
    req = 2'b00;
    @(posedge clk); #1;
    check("rd err cleared", {err, timeout, done}, 0);

    // Contention: alternating grants, one idle cycle between transfers.
    set_client(0, 1'b1, 5'd2, 32'h0BAD_F00D, 3'b001);
    set_client(1, 1'b0, 5'd3, 32'h0, 3'b010);
    push(2'b01, 1'b0, 1'b0);
    model_rdata = 32'hCAFE_0001;
    push(2'b10, 1'b0, 1'b0);
    push(2'b01, 1'b0, 1'b0);
    model_rdata = 32'hCAFE_0002;
    push(2'b10, 1'b0, 1'b0);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_grant($sformatf("cont%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, idle);
      if (i > 0) check($sformatf("cont%0d idle cycles", i), idle, 1);
      if (i % 2 == 0) check_bus($sformatf("cont%0d", i), 1'b1, 5'd2, 32'h0BAD_F00D, 3'b001);
      else            check_bus($sformatf("cont%0d", i), 1'b0, 5'd3, 32'h0, 3'b010);
      if (i == 3) req = 2'b00;
      finish($sformatf("cont%0d", i), 0, 1'b0, (i == 1) ? 32'hCAFE_0001 : 32'hCAFE_0002,
             1'b0, edges);
    end

    // Watchdog: pready stuck low; rdata keeps the last read value.
    set_client(0, 1'b0, 5'd4, 32'h0, 3'b100);
    push(2'b01, 1'b1, 1'b1);
    req = 2'b01;
    wait_grant("to", 2'b01, idle);
    check_bus("to", 1'b0, 5'd4, 32'h0, 3'b100);
    finish("to", 0, 1'b0, 32'h0, 1'b1, edges);
    check("to latency", edges, 17);
    req = 2'b00;

    set_client(1, 1'b1, 5'd5, 32'h5555_AAAA, 3'b011);
    push(2'b10, 1'b0, 1'b0);
    req = 2'b10;
    wait_grant("post-to", 2'b10, idle);
    check_bus("post-to", 1'b1, 5'd5, 32'h5555_AAAA, 3'b011);
    finish("post-to", 0, 1'b0, 32'h0, 1'b0, edges);
    req = 2'b00;

    // Reset asserted in ACCESS: bus drops at once, no completion.
    set_client(1, 1'b0, 5'd6, 32'h0, 3'b000);
    req = 2'b10;
    wait_grant("rstmid", 2'b10, idle);
    @(posedge clk); #1;
    check("rstmid access", {psel, penable}, 2'b11);
    #2 resetn = 1'b0;
    #1;
    check("rstmid async drop", {psel, penable}, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rstmid no done", done, 0);
    end
    check_zero("rstmid");
    set_client(0, 1'b1, 5'd7, 32'h0000_0077, 3'b000);
    model_rdata = 32'h0;
    push(2'b01, 1'b0, 1'b0);
    req = 2'b11;
    resetn = 1'b1;
    wait_grant("post-rst", 2'b01, idle);
    req = 2'b00;
    check_bus("post-rst", 1'b1, 5'd7, 32'h0000_0077, 3'b000);
    finish("post-rst", 0, 1'b0, 32'h0, 1'b0, edges);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard drained", sb.size(), 0);
    check("psel without gnt", psel_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
